// File: rtl/spi_arb_if.sv
// Signal bundle between spi_arb, its two clients (A2D, inertial sensor) and the shared SPI_mnrch master.
// The slave modport is the arbiter's view; the master modport is the view of everything around it.
interface spi_arb_if;
  logic        req0, req1;
  logic        lock0, lock1;
  logic        wrt0, wrt1;
  logic [15:0] wt_data0, wt_data1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic [15:0] rd_data0, rd_data1;
  logic        m_wrt;
  logic [15:0] m_wt_data;
  logic        m_done;
  logic [15:0] m_rd_data;
  logic        m_SS_n;
  logic        SS_n0, SS_n1;
  logic        hold_viol;
  logic        wdog_err;

  modport slave (
    input  req0, req1, lock0, lock1, wrt0, wrt1, wt_data0, wt_data1,
    input  m_done, m_rd_data, m_SS_n,
    output gnt0, gnt1, done0, done1, rd_data0, rd_data1,
    output m_wrt, m_wt_data, SS_n0, SS_n1, hold_viol, wdog_err
  );

  modport master (
    output req0, req1, lock0, lock1, wrt0, wrt1, wt_data0, wt_data1,
    output m_done, m_rd_data, m_SS_n,
    input  gnt0, gnt1, done0, done1, rd_data0, rd_data1,
    input  m_wrt, m_wt_data, SS_n0, SS_n1, hold_viol, wdog_err
  );
endinterface

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI_mnrch master between client 0 (A2D) and client 1 (inertial).
// Optional transaction watchdog enabled by defining SPI_ARB_WDOG_EN.
module spi_arb #(
  parameter int HOLD_MAX = 255,
  parameter int WDOG_CYC = 4095
) (
  input logic     clk,
  input logic     rst_n,
  spi_arb_if.slave bus
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  if (HOLD_MAX < 1 || WDOG_CYC < 1 || WDOG_CYC > 4095) begin : g_param_check
    $error("spi_arb: HOLD_MAX must be >= 1 and WDOG_CYC must fit the 12-bit watchdog");
  end

  typedef enum logic [1:0] {IDLE, GNT, XFER, HOLD} state_t;

  state_t        state;
  logic          owner;
  logic          last;
  logic          gnt0_q, gnt1_q;
  logic          hold_viol_q;
  logic [HW-1:0] hold_cnt;
  logic          req_own, lock_own, wrt_own;
  logic          pick;

  assign req_own  = owner ? bus.req1  : bus.req0;
  assign lock_own = owner ? bus.lock1 : bus.lock0;
  assign wrt_own  = owner ? bus.wrt1  : bus.wrt0;

  // On a tie the client that was not served last wins.
  assign pick = (bus.req0 && bus.req1) ? ~last : bus.req1;

`ifdef SPI_ARB_WDOG_EN
  logic [11:0] wdog_cnt;
  logic        wdog_err_q;

  // Zero whenever outside XFER, so it always starts from 0 on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wdog_cnt <= '0;
    else if (state != XFER)  wdog_cnt <= '0;
    else                     wdog_cnt <= wdog_cnt + 12'd1;
  end

  assign bus.wdog_err = wdog_err_q;
`else
  assign bus.wdog_err = 1'b0;
`endif

  // NOTE: state and all registered outputs use non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last        <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      hold_cnt    <= '0;
      hold_viol_q <= 1'b0;
`ifdef SPI_ARB_WDOG_EN
      wdog_err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner  <= pick;
            gnt0_q <= ~pick;
            gnt1_q <= pick;
            state  <= GNT;
          end
        end
        GNT: begin
          if (wrt_own) begin
            state <= XFER;
          end else if (!req_own) begin
            state  <= IDLE;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
          end
        end
        XFER: begin
          if (bus.m_done) begin
            last <= owner;
            if (lock_own) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end else begin
              state  <= IDLE;
              gnt0_q <= 1'b0;
              gnt1_q <= 1'b0;
            end
          end
`ifdef SPI_ARB_WDOG_EN
          else if (wdog_cnt == 12'(WDOG_CYC - 1)) begin
            last       <= owner;
            wdog_err_q <= 1'b1;
            state      <= IDLE;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
          end
`endif
        end
        HOLD: begin
          if (wrt_own) begin
            state <= XFER;
          end else if (!lock_own || !req_own) begin
            state  <= IDLE;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
          end else if (hold_cnt == HW'(HOLD_MAX - 1)) begin
            hold_viol_q <= 1'b1;
            state       <= IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.hold_viol = hold_viol_q;

  // Master-facing strobes pass straight through so the SPI master sees no added latency.
  assign bus.m_wrt     = ((state == GNT) || (state == HOLD)) && wrt_own;
  assign bus.m_wt_data = gnt1_q ? bus.wt_data1 : bus.wt_data0;
  assign bus.done0     = bus.m_done && (state == XFER) && !owner;
  assign bus.done1     = bus.m_done && (state == XFER) && owner;
  assign bus.rd_data0  = bus.m_rd_data;
  assign bus.rd_data1  = bus.m_rd_data;
  assign bus.SS_n0     = gnt0_q ? bus.m_SS_n : 1'b1;
  assign bus.SS_n1     = gnt1_q ? bus.m_SS_n : 1'b1;

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed scenarios plus randomized rounds scored against
// a transaction-level model of grant order, routing and lock behaviour.
module tb_spi_arb;
  localparam int HOLD_MAX = 255;
  localparam int WDOG_CYC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_arb_if bus();

  spi_arb #(.HOLD_MAX(HOLD_MAX), .WDOG_CYC(WDOG_CYC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int last_srv = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic gnt_of(input int c);
    return (c == 1) ? bus.gnt1 : bus.gnt0;
  endfunction
  function automatic logic done_of(input int c);
    return (c == 1) ? bus.done1 : bus.done0;
  endfunction
  function automatic logic ssn_of(input int c);
    return (c == 1) ? bus.SS_n1 : bus.SS_n0;
  endfunction
  function automatic logic [15:0] rd_of(input int c);
    return (c == 1) ? bus.rd_data1 : bus.rd_data0;
  endfunction

  task automatic set_req(input int c, input logic v);
    if (c == 1) bus.req1 = v; else bus.req0 = v;
  endtask
  task automatic set_lock(input int c, input logic v);
    if (c == 1) bus.lock1 = v; else bus.lock0 = v;
  endtask
  task automatic set_wrt(input int c, input logic v);
    if (c == 1) bus.wrt1 = v; else bus.wrt0 = v;
  endtask
  task automatic set_data(input int c, input logic [15:0] v);
    if (c == 1) bus.wt_data1 = v; else bus.wt_data0 = v;
  endtask

  task automatic check_gnt(input string tag, input int exp_owner);
    check({tag, "/gnt0"}, bus.gnt0, (exp_owner == 0) ? 1 : 0);
    check({tag, "/gnt1"}, bus.gnt1, (exp_owner == 1) ? 1 : 0);
  endtask

  // Starts at a negedge with client c granted (GNT or HOLD); returns at the negedge
  // after the done edge, having checked that the grant is kept exactly when locked.
  task automatic do_xfer(input int c, input logic [15:0] data, input int lat,
                         input logic lock_after, input string tag);
    int o;
    logic [15:0] rd;
    o = 1 - c;
    @(negedge clk);
    set_wrt(c, 1'b1);
    set_data(c, data);
    set_wrt(o, 1'($urandom_range(0, 1)));
    set_data(o, 16'($urandom));
    #1;
    check({tag, "/m_wrt_start"}, bus.m_wrt, 1);
    check({tag, "/m_wt_data"}, bus.m_wt_data, data);
    check({tag, "/other_gnt"}, gnt_of(o), 0);
    @(negedge clk);
    set_wrt(o, 1'b0);
    bus.m_SS_n = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (i != 0) @(negedge clk);
      set_wrt(c, 1'($urandom_range(0, 1)));
      #1;
      check({tag, "/m_wrt_xfer"}, bus.m_wrt, 0);
      check({tag, "/ss_owner"}, ssn_of(c), 0);
      check({tag, "/ss_other"}, ssn_of(o), 1);
      check({tag, "/early_done"}, done_of(c), 0);
    end
    @(negedge clk);
    set_wrt(c, 1'($urandom_range(0, 1)));
    set_lock(c, lock_after);
    rd = 16'($urandom);
    bus.m_done = 1'b1;
    bus.m_rd_data = rd;
    #1;
    check({tag, "/done_owner"}, done_of(c), 1);
    check({tag, "/done_other"}, done_of(o), 0);
    check({tag, "/rd_data"}, rd_of(c), rd);
    check({tag, "/m_wrt_done"}, bus.m_wrt, 0);
    @(negedge clk);
    bus.m_done = 1'b0;
    bus.m_SS_n = 1'b1;
    set_wrt(c, 1'b0);
    #1;
    check({tag, "/gnt_after"}, gnt_of(c), lock_after);
    check({tag, "/other_after"}, gnt_of(o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int exp_c;
    bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
    bus.wrt0 = 0; bus.wrt1 = 0;
    bus.wt_data0 = 16'hA5A5; bus.wt_data1 = 16'h5A5A;
    bus.m_done = 0; bus.m_rd_data = 16'h0; bus.m_SS_n = 1;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check_gnt("reset", -1);
    check("reset/done0", bus.done0, 0);
    check("reset/done1", bus.done1, 0);
    check("reset/m_wrt", bus.m_wrt, 0);
    check("reset/ss0", bus.SS_n0, 1);
    check("reset/ss1", bus.SS_n1, 1);
    check("reset/hold_viol", bus.hold_viol, 0);
    check("reset/wdog_err", bus.wdog_err, 0);
    check("reset/idle_data", bus.m_wt_data, 16'hA5A5);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, one-cycle grant latency
    @(negedge clk);
    set_req(0, 1);
    #1;
    check_gnt("t1_latency", -1);
    @(negedge clk);
    #1;
    check_gnt("t1_grant", 0);
    do_xfer(0, 16'h2000, 3, 1'b0, "t1");
    set_req(0, 0);
    last_srv = 0;

    // Tie after reset: strict alternation over four grants
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_srv = 1;
    set_req(0, 1);
    set_req(1, 1);
    for (int g = 0; g < 4; g++) begin
      exp_c = 1 - last_srv;
      @(negedge clk);
      #1;
      check_gnt($sformatf("t2_grant%0d", g), exp_c);
      do_xfer(exp_c, 16'($urandom), 2, 1'b0, "t2");
      last_srv = exp_c;
    end
    set_req(0, 0);
    set_req(1, 0);

    // Locked two-transaction sequence by client 0 while client 1 waits
    @(negedge clk);
    set_req(0, 1);
    set_req(1, 1);
    set_lock(0, 1);
    @(negedge clk);
    #1;
    check_gnt("t3_grant", 0);
    do_xfer(0, 16'h2000, 2, 1'b1, "t3a");
    do_xfer(0, 16'h0000, 2, 1'b1, "t3b");
    last_srv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check_gnt("t3_held", 0);
    end
    set_lock(0, 0);
    @(negedge clk);
    #1;
    check_gnt("t3_release", -1);
    @(negedge clk);
    #1;
    check_gnt("t3_handover", 1);
    do_xfer(1, 16'h1234, 2, 1'b0, "t3c");
    last_srv = 1;
    set_req(0, 0);
    set_req(1, 0);

    // Forced HOLD release after HOLD_MAX idle cycles
    @(negedge clk);
    set_req(0, 1);
    @(negedge clk);
    #1;
    check_gnt("t4_grant", 0);
    do_xfer(0, 16'h2000, 2, 1'b1, "t4");
    last_srv = 0;
    repeat (HOLD_MAX - 1) @(negedge clk);
    #1;
    check("t4/gnt_before_limit", bus.gnt0, 1);
    check("t4/viol_before_limit", bus.hold_viol, 0);
    @(negedge clk);
    #1;
    check("t4/gnt_at_limit", bus.gnt0, 0);
    check("t4/viol_at_limit", bus.hold_viol, 1);
    set_lock(0, 0);
    set_req(0, 0);
    repeat (5) @(negedge clk);
    #1;
    check("t4/viol_sticky", bus.hold_viol, 1);

    // Reset in the middle of a transfer
    set_req(0, 1);
    set_req(1, 1);
    exp_c = 1 - last_srv;
    @(negedge clk);
    #1;
    check_gnt("t5_grant", exp_c);
    set_wrt(exp_c, 1'b1);
    @(negedge clk);
    set_wrt(exp_c, 1'b0);
    bus.m_SS_n = 1'b0;
    #1;
    check("t5/ss_selected", ssn_of(exp_c), 0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.m_done = 1'b1;
    #1;
    check_gnt("t5_reset", -1);
    check("t5/ss0", bus.SS_n0, 1);
    check("t5/ss1", bus.SS_n1, 1);
    check("t5/done0", bus.done0, 0);
    check("t5/done1", bus.done1, 0);
    check("t5/hold_viol", bus.hold_viol, 0);
    @(negedge clk);
    bus.m_done = 1'b0;
    bus.m_SS_n = 1'b1;
    rst_n = 1'b1;
    last_srv = 1;
    @(negedge clk);
    #1;
    check_gnt("t5_first_tie", 0);
    set_req(0, 0);
    set_req(1, 0);
    @(negedge clk);
    #1;
    check_gnt("t5_abandon", -1);

    // Transfer that never completes
    set_req(0, 1);
    @(negedge clk);
    #1;
    check_gnt("t6_grant", 0);
    set_wrt(0, 1'b1);
    set_data(0, 16'h2000);
    @(negedge clk);
    set_wrt(0, 1'b0);
    bus.m_SS_n = 1'b0;
`ifdef SPI_ARB_WDOG_EN
    repeat (WDOG_CYC - 1) @(negedge clk);
    #1;
    check("t6/gnt_before_wdog", bus.gnt0, 1);
    check("t6/err_before_wdog", bus.wdog_err, 0);
    @(negedge clk);
    #1;
    check("t6/gnt_at_wdog", bus.gnt0, 0);
    check("t6/err_at_wdog", bus.wdog_err, 1);
    check("t6/no_done", bus.done0, 0);
    bus.m_SS_n = 1'b1;
`else
    repeat (WDOG_CYC + 20) @(negedge clk);
    #1;
    check("t6/gnt_waiting", bus.gnt0, 1);
    check("t6/no_wdog_err", bus.wdog_err, 0);
    bus.m_done = 1'b1;
    #1;
    check("t6/late_done", bus.done0, 1);
    @(negedge clk);
    bus.m_done = 1'b0;
    bus.m_SS_n = 1'b1;
`endif
    last_srv = 0;
    set_req(0, 0);
    @(negedge clk);

    // Randomized rounds against the transaction-level model
    for (int r = 0; r < 150; r++) begin
      int pat, win, n;
      pat = $urandom_range(1, 3);
      set_req(0, pat[0]);
      set_req(1, pat[1]);
      set_lock(0, 0);
      set_lock(1, 0);
      win = (pat == 3) ? 1 - last_srv : ((pat == 2) ? 1 : 0);
      set_wrt(win, 1'b1);
      #1;
      check("rnd/idle_wrt_ignored", bus.m_wrt, 0);
      @(negedge clk);
      set_wrt(win, 1'b0);
      #1;
      check_gnt("rnd_grant", win);
      if ($urandom_range(0, 5) == 0) begin
        set_req(0, 0);
        set_req(1, 0);
        @(negedge clk);
        #1;
        check_gnt("rnd_abandon", -1);
      end else begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++)
          do_xfer(win, 16'($urandom), $urandom_range(1, 4), (k != n - 1), "rnd");
        last_srv = win;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
